// File: rtl/logic_unit_pipe_if.sv
// Handshake and data bundle for logic_unit_pipe: the operand side (valid_i/ready_o)
// and the result side (valid_o/ready_i) of the pipelined logic unit.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;

    modport slave (
        input  valid_i, op_i, a_i, b_i, ready_i,
        output ready_o, valid_o, result_o, zero_o
    );

    modport master (
        output valid_i, op_i, a_i, b_i, ready_i,
        input  ready_o, valid_o, result_o, zero_o
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit (OR/AND/XOR/NOR) with zero flag, full backpressure
// and flush. The result is computed before stage 1; later stages only forward it.
module logic_unit_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    logic_unit_pipe_if.slave bus
);
    logic [STAGES:1]            vld_q, vld_d;
    logic [STAGES:1][WIDTH-1:0] data_q, data_d;
    logic [STAGES:1]            zero_q, zero_d;
    logic [STAGES:1]            can_load;
    logic [WIDTH-1:0]           op_res;
    logic                       accept;

    always_comb begin
        case (bus.op_i)
            2'b00:   op_res = bus.a_i | bus.b_i;
            2'b01:   op_res = bus.a_i & bus.b_i;
            2'b10:   op_res = bus.a_i ^ bus.b_i;
            default: op_res = ~(bus.a_i | bus.b_i);
        endcase
    end

    // A stage may load if it, or any stage downstream of it, is empty, or the
    // consumer is taking the result; walking from the output keeps this acyclic.
    always_comb begin : stall_chain
        logic open;
        open     = bus.ready_i;
        can_load = '0;
        for (int k = STAGES; k >= 1; k--) begin
            open        = open || !vld_q[k];
            can_load[k] = open;
        end
    end

    assign bus.ready_o = can_load[1] && !rst_i && !flush_i;
    assign accept      = bus.valid_i && bus.ready_o;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        zero_d = zero_q;
        if (can_load[1]) begin
            vld_d[1] = accept;
            if (accept) begin
                data_d[1] = op_res;
                zero_d[1] = ~|op_res;
            end
        end
        for (int k = 2; k <= STAGES; k++) begin
            if (can_load[k]) begin
                vld_d[k] = vld_q[k-1];
                // Data moves only with a valid op, so outputs stay quiet behind bubbles.
                if (vld_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                    zero_d[k] = zero_q[k-1];
                end
            end
        end
        if (flush_i) begin
            vld_d  = '0;
            data_d = data_q;
            zero_d = zero_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q  <= '0;
            data_q <= '0;
            zero_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            zero_q <= zero_d;
        end
    end

    assign bus.valid_o  = vld_q[STAGES];
    assign bus.result_o = data_q[STAGES];
    assign bus.zero_o   = zero_q[STAGES];
endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined bitwise logic unit for the execute stage. Generalises the fixed 32-bit combinational OR to configurable width and pipeline depth, adds selectable operations (OR/AND/XOR/NOR), a zero flag, a valid/ready handshake with full backpressure, and a synchronous flush for branch-mispredict recovery.

## Interface

- WIDTH, 32: operand and result width in bits; must be ≥1.
- STAGES, 2: pipeline depth in register stages; must be ≥1.

- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- flush_i  input  1  synchronous flush; discards all in-flight operations.
- valid_i  input  1  input operation is valid.
- ready_o  output  1  unit can accept an operation this cycle.
- op_i  input  2  operation select: 00 OR, 01 AND, 10 XOR, 11 NOR.
- a_i  input  WIDTH  operand A.
- b_i  input  WIDTH  operand B.
- valid_o  output  1  result_o and zero_o hold a valid result.
- ready_i  input  1  downstream accepts the result this cycle.
- result_o  output  WIDTH  bitwise result.
- zero_o  output  1  1 when result_o is all zeros.

## Operation

- Accept (input handshake) occurs on a rising edge where valid_i=1 and ready_o=1. Transfer (output handshake) occurs on a rising edge where valid_o=1 and ready_i=1.
- Result is computed combinationally from a_i, b_i and op_i and captured into stage 1 on accept. Stages 2..STAGES only forward data; the final stage drives result_o, zero_o and valid_o.
- Ops: OR = a|b, AND = a&b, XOR = a^b, NOR = ~(a|b), all over the full WIDTH. zero_o = ~|result, computed alongside the result at stage 1 and carried with it.
- Each stage k holds a valid bit v[k], plus data and zero. Stage k may load when it is empty or when it is advancing this cycle. The last stage advances when ready_i=1; stage k<STAGES advances when stage k+1 may load.
- ready_o = stage 1 may load AND rst_i=0 AND flush_i=0. This is combinational from ready_i through the stall chain; there is no combinational path from valid_i to ready_o.
- A stalled stage holds data, zero and valid unchanged. Once valid_o rises, result_o, zero_o and valid_o stay stable until transfer.
- A bubble does not block: an empty stage always loads from its predecessor, so gaps collapse under backpressure.
- flush_i=1: every v[k] clears on the next edge. No accept occurs that cycle (ready_o=0). Data registers may keep stale values. A transfer presented in the flush cycle still completes, because valid_o was 1 on that edge; the consumer is responsible for ignoring it.
- rst_i=1: every v[k] clears, and every data and zero register clears to 0. rst_i has priority over flush_i and all handshakes. Reset asserted mid-operation drops all in-flight operations.

## Timing

- Reset values: valid_o=0, result_o=0, zero_o=0. ready_o=0 while rst_i=1, and 1 on the first cycle after rst_i deasserts.
- Latency: an operation accepted at edge N appears with valid_o=1 after edge N+STAGES−1, i.e. it is available for transfer at edge N+STAGES, provided there are no stalls.
- Throughput: one operation per cycle while ready_i stays 1.
- Capacity: STAGES operations in flight. With ready_i=0, ready_o falls only once all STAGES slots are full.
- After ready_i rises, ready_o rises in the same cycle (combinational), allowing simultaneous accept and transfer when full.
- Data registers update only on load, so result_o does not toggle while valid_o=0 after a flush.

## Test plan

- Reset/ops (WIDTH=32, STAGES=2): a=0xF0F0_00FF, b=0x0FF0_0F0F. Expect results two edges after accept: OR 0xFFF0_0FFF, AND 0x00F0_000F, XOR 0xFF00_0FF0, NOR 0x000F_F000. zero_o=0 throughout. All outputs are 0 during reset.
- Zero flag: AND with a=0xAAAA_AAAA, b=0x5555_5555 → result_o=0, zero_o=1. NOR with a=b=0xFFFF_FFFF → zero_o=1.
- Backpressure: stream 5 ops with ready_i=0. Expect ready_o to drop after 2 accepts, and valid_o/result_o held stable. Raise ready_i → 5 results in order, no loss or duplication, with ready_o rising in the same cycle as ready_i.
- Bubbles: feed valid_i pattern 1,0,1 with ready_i toggling 0,1. Expect the results in order and no spurious valid_o.
- Flush: with 2 ops in flight, pulse flush_i together with valid_i=1. Expect that op is not accepted, valid_o=0 on the next cycle, and the following op completes normally with latency STAGES.
- Parameter sweep: WIDTH=1, STAGES=1 (single bit, NOR 0,0 → 1, latency 1); WIDTH=64, STAGES=4 (XOR of all ones and 0 → all ones, latency 4). Randomised ops and stalls are checked against a reference model.
